sr_excitation_driver: RTL
=========================

Name: sr_excitation_driver

Overview:
- Drives a bank of WIDTH clocked SR flip-flops to a requested target word. This is the opposite direction of SR flop stimulus: the block takes the desired Q and produces the S/R excitation.
- For each requested word it computes per-bit S/R from the current Q feedback and pulses it for one cycle. It then watches the feedback until Q equals the target, or a timeout expires.
- It sits between a control sequencer (valid/ready request side) and the SR register bank (s_out/r_out to the flops, q_fb from the flops).

Parameters:
- WIDTH, 4, number of SR flip-flops driven (1..32).
- TIMEOUT, 8, number of CHECK-state samples allowed before declaring failure (>=1).
- MAX_RETRY, 2, extra drive attempts after a timeout; used only when SR_DRV_RETRY_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- tgt_valid  input  1  request strobe; tgt_data is valid.
- tgt_data  input  WIDTH  desired Q word.
- tgt_ready  output  1  high when in IDLE; a request is accepted on the edge where tgt_valid and tgt_ready are both high.
- q_fb  input  WIDTH  Q outputs of the driven SR flops.
- s_out  output  WIDTH  set excitation to the flops (registered).
- r_out  output  WIDTH  reset excitation to the flops (registered).
- busy  output  1  high in DRIVE and CHECK.
- done  output  1  one-cycle pulse: target reached.
- err  output  1  one-cycle pulse: target not reached within the allowed time.

Behaviour:
- Reset (reset=0, takes effect asynchronously):
  - state=IDLE; s_out=0, r_out=0, done=0, err=0, busy=0, tgt_ready=1.
  - Target register and counters are cleared.
  - Reset asserted mid-DRIVE drops s_out/r_out to 0 immediately.
- Per-bit excitation, computed from q_fb sampled on the accept edge:
  - q=0, t=1 -> s=1, r=0.
  - q=1, t=0 -> s=0, r=1.
  - q==t -> s=0, r=0.
  - s=r=1 is never produced on any bit in any cycle.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - tgt_ready=1.
  - On accept edge E0: latch tgt_data, register the excitation into s_out/r_out, go to DRIVE.
  - tgt_valid without acceptance has no effect.
- DRIVE (exactly one cycle, after E0):
  - s_out/r_out hold the excitation; busy=1.
  - At edge E1: the flops capture; s_out/r_out return to 0; the check counter is cleared; go to CHECK.
- CHECK:
  - s_out=r_out=0, busy=1.
  - Each edge samples (q_fb == target).
  - On a match: done=1 in the following cycle; go to IDLE.
  - If TIMEOUT samples have been taken without a match: err=1 in the following cycle; go to IDLE.
  - A match on the TIMEOUT-th sample counts as done, not err.
- Latency: with a responsive flop bank, done is high in the cycle after E2 (two edges after accept).
- Handshake timing:
  - done/err pulse exactly one cycle and never together.
  - tgt_ready is high in the same cycle as the done/err pulse, so a back-to-back request is accepted on the next edge.
- A target equal to current Q still passes through DRIVE (all-zero excitation) and CHECK, and yields done.
- tgt_data changes while busy are ignored; the latched target is used.

Optional Feature:
- Macro: SR_DRV_RETRY_EN.
- Defined:
  - On a CHECK timeout with fewer than MAX_RETRY retries used, the block recomputes the excitation from the current q_fb and the latched target, and re-enters DRIVE with a fresh check counter.
  - err is raised only after MAX_RETRY retries have also timed out.
  - The retry count resets on every accept.
- Undefined: err on the first timeout; MAX_RETRY is ignored; no retry logic is synthesized.

Test Plan:
1. Pull reset=0 for 2 cycles while in DRIVE with s_out=1010 -> s_out/r_out drop to 0000 asynchronously; busy=0, done=err=0, tgt_ready=1; next request is accepted normally.
2. Bench model of 4 clocked SR flops, q_fb=0000, request 1010 -> one DRIVE cycle with s_out=1010, r_out=0000; q_fb=1010 after E1; done pulse in the cycle after E2; s_out/r_out=0 otherwise.
3. q_fb=1111, request 0110 -> s_out=0000, r_out=1001 for one cycle; q_fb=0110; done; then back-to-back request 0000 accepted the edge after done -> r_out=0110.
4. q_fb=0101, request 0101 -> s_out=r_out=0000 in DRIVE; done two edges after accept; no err.
5. Feedback stuck at 0000, request 0001 -> s_out=0001 pulse, then 8 CHECK cycles and an err pulse, no done. With SR_DRV_RETRY_EN and MAX_RETRY=2 -> three s_out=0001 pulses, err after the third timeout.
6. Random 200 requests with random tgt_valid, including valid held high while busy -> only IDLE handshakes are accepted; s_out&r_out==0 on every cycle (assertion); exactly one done per accepted request.

Source files
------------

// File: rtl/sr_excitation_driver.sv
// Drives a bank of clocked SR flops toward a requested Q word and waits for the feedback to match.
// Optional SR_DRV_RETRY_EN: re-drive up to MAX_RETRY times after a check timeout before raising err.
module sr_excitation_driver #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             retry_ok;
    logic             retry_start;
    logic             retry_inc;

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        s_d         = '0;
        r_d         = '0;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        retry_start = 1'b0;
        retry_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tgt_valid) begin
                    tgt_d       = tgt_data;
                    // s and r are disjoint by construction: s needs t=1, r needs t=0
                    s_d         = tgt_data & ~q_fb;
                    r_d         = ~tgt_data & q_fb;
                    retry_start = 1'b1;
                    state_d     = StDrive;
                end
            end
            StDrive: begin
                cnt_d   = '0;
                state_d = StCheck;
            end
            StCheck: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    if (retry_ok) begin
                        s_d       = tgt_q & ~q_fb;
                        r_d       = ~tgt_q & q_fb;
                        retry_inc = 1'b1;
                        state_d   = StDrive;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef SR_DRV_RETRY_EN
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RetryW-1:0] retry_q, retry_d;

    assign retry_ok = (int'(retry_q) < int'(MAX_RETRY));

    always_comb begin
        retry_d = retry_q;
        if (retry_start) begin
            retry_d = '0;
        end else if (retry_inc) begin
            retry_d = retry_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`else
    // Without retries the first timeout is final; MAX_RETRY stays in the parameter list only.
    logic unused_retry;
    assign retry_ok     = 1'b0;
    assign unused_retry = ^{retry_start, retry_inc, MAX_RETRY};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tgt_ready = (state_q == StIdle);
    assign busy      = (state_q == StDrive) || (state_q == StCheck);
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
